// File: rtl/invader_pkg.sv
// ----------------------------------------------------------------------------
// invader_pkg
// Shared definitions for the invader sprite renderer:
//   - default sprite bitmap dimensions (SPR_W_DEF x SPR_H_DEF)
//   - foreground, background and bounding-box colour constants
//   - rgb4_t, a packed 4-bit-per-channel colour
//   - the two 16x8 animation bitmaps and a lookup helper
// Bitmap rows are 16-bit words; column 0 is the MSB of each word.
// ----------------------------------------------------------------------------
package invader_pkg;

  localparam int SPR_W_DEF = 16;
  localparam int SPR_H_DEF = 8;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb4_t;

  localparam logic [3:0] FG_R   = 4'hF;
  localparam logic [3:0] FG_G   = 4'hF;
  localparam logic [3:0] FG_B   = 4'hF;
  localparam logic [3:0] BG_R   = 4'h1;
  localparam logic [3:0] BG_G   = 4'h3;
  localparam logic [3:0] BG_B   = 4'h7;
  localparam logic [3:0] BBOX_R = 4'hF;
  localparam logic [3:0] BBOX_G = 4'h0;
  localparam logic [3:0] BBOX_B = 4'h0;

  localparam rgb4_t FG_RGB    = '{r: FG_R,   g: FG_G,   b: FG_B};
  localparam rgb4_t BG_RGB    = '{r: BG_R,   g: BG_G,   b: BG_B};
  localparam rgb4_t BBOX_RGB  = '{r: BBOX_R, g: BBOX_G, b: BBOX_B};
  localparam rgb4_t BLACK_RGB = '{r: 4'h0,   g: 4'h0,   b: 4'h0};

  // Animation frame A: legs tucked in.
  localparam logic [15:0] SPRITE_A [SPR_H_DEF] = '{
    16'h0810,
    16'h0420,
    16'h0FF0,
    16'h1BD8,
    16'h3FFC,
    16'h2FF4,
    16'h2814,
    16'h0660
  };

  // Animation frame B: arms raised, legs spread.
  localparam logic [15:0] SPRITE_B [SPR_H_DEF] = '{
    16'h0810,
    16'h2424,
    16'h2FF4,
    16'h3BDC,
    16'h3FFC,
    16'h0FF0,
    16'h0810,
    16'h1008
  };

  // Looks up one bitmap bit; column 0 is the leftmost pixel, stored in the MSB.
  function automatic logic sprite_bit(input logic       anim,
                                      input logic [2:0] row,
                                      input logic [3:0] col);
    logic [15:0] word;
    word = anim ? SPRITE_B[row] : SPRITE_A[row];
    return word[4'd15 - col];
  endfunction

endpackage

// File: rtl/sprite_pos_latch.sv
// ----------------------------------------------------------------------------
// sprite_pos_latch
// Holds the sprite position requested by game logic and commits it to the
// renderer only at the start of vertical blank, so a frame is never drawn with
// two different positions. Also runs the animation frame counter.
//
// Ports:
//   clk_pix, rst_pix  pixel clock, synchronous active-high reset
//   sx, sy            raster position (stage-0), used to spot the commit event
//   pos_x, pos_y      requested sprite top-left corner
//   pos_valid         single-cycle strobe capturing pos_x/pos_y
//   cx, cy            committed sprite position used for drawing
//   anim              animation bitmap select
// ----------------------------------------------------------------------------
module sprite_pos_latch #(
  parameter int CORDW       = 10,
  parameter int V_RES       = 480,
  parameter int ANIM_FRAMES = 30
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic [CORDW-1:0] pos_x,
  input  logic [CORDW-1:0] pos_y,
  input  logic             pos_valid,
  output logic [CORDW-1:0] cx,
  output logic [CORDW-1:0] cy,
  output logic             anim
);

  localparam int CNT_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_FRAMES - 1);

  logic [CORDW-1:0] pend_x;
  logic [CORDW-1:0] pend_y;
  logic [CNT_W-1:0] frame_cnt;
  logic             commit;

  // The first pixel of the first blanking line marks the frame boundary.
  assign commit = (sx == '0) && (sy == CORDW'(V_RES));

  // Pending position follows every strobe. At the frame boundary the committed
  // position takes the pending value, or the strobed value directly when the
  // strobe lands on the same cycle, so a late update is not lost for a frame.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      pend_x <= '0;
      pend_y <= '0;
      cx     <= '0;
      cy     <= '0;
    end else begin
      if (pos_valid) begin
        pend_x <= pos_x;
        pend_y <= pos_y;
      end
      if (commit) begin
        cx <= pos_valid ? pos_x : pend_x;
        cy <= pos_valid ? pos_y : pend_y;
      end
    end
  end

  // Counts frames at each boundary; on reaching the last count it wraps and
  // flips the bitmap select, so one bitmap is shown for ANIM_FRAMES frames.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      frame_cnt <= '0;
      anim      <= 1'b0;
    end else if (commit) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
        anim      <= ~anim;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/invader_sprite_renderer.sv
// ----------------------------------------------------------------------------
// invader_sprite_renderer
// Pixel-pipeline stage that draws one scaled, two-frame animated invader over
// a flat background. Fixed latency of 2 pixel clocks; sync and data enable are
// delayed to stay aligned with the colour.
//
// Ports:
//   clk_pix, rst_pix         pixel clock, synchronous active-high reset
//   sx, sy                   raster position from the display controller
//   hsync, vsync, de         timing from the display controller
//   pos_x, pos_y, pos_valid  sprite position update from game logic
//   hsync_o, vsync_o, de_o   timing delayed by 2 cycles
//   r_o, g_o, b_o            4-bit colour
//
// Build option: define SPRITE_BBOX_EN to outline the scaled sprite box with a
// 1-pixel red border drawn over the bitmap.
// ----------------------------------------------------------------------------
module invader_sprite_renderer
  import invader_pkg::*;
#(
  parameter int CORDW       = 10,
  parameter int V_RES       = 480,
  parameter int SPR_W       = SPR_W_DEF,
  parameter int SPR_H       = SPR_H_DEF,
  parameter int SCALE_LOG2  = 2,
  parameter int ANIM_FRAMES = 30
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  input  logic [CORDW-1:0] pos_x,
  input  logic [CORDW-1:0] pos_y,
  input  logic             pos_valid,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic [3:0]       r_o,
  output logic [3:0]       g_o,
  output logic [3:0]       b_o
);

  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);
  localparam logic [CORDW:0] BOX_W = (CORDW+1)'(SPR_W << SCALE_LOG2);
  localparam logic [CORDW:0] BOX_H = (CORDW+1)'(SPR_H << SCALE_LOG2);

  logic [CORDW-1:0] cx;
  logic [CORDW-1:0] cy;
  logic             anim;

  logic [CORDW:0]   dx_c;
  logic [CORDW:0]   dy_c;
  logic             in_spr_c;

  logic [CORDW:0]   s1_dx;
  logic [CORDW:0]   s1_dy;
  logic             s1_in_spr;
  logic             s1_hsync;
  logic             s1_vsync;
  logic             s1_de;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             spr_bit;
  rgb4_t            pix;

  sprite_pos_latch #(
    .CORDW       (CORDW),
    .V_RES       (V_RES),
    .ANIM_FRAMES (ANIM_FRAMES)
  ) u_pos_latch (
    .clk_pix   (clk_pix),
    .rst_pix   (rst_pix),
    .sx        (sx),
    .sy        (sy),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .pos_valid (pos_valid),
    .cx        (cx),
    .cy        (cy),
    .anim      (anim)
  );

  // Offsets are one bit wider than the coordinates so that a sprite placed
  // near the right/bottom edge clips instead of wrapping back to the left/top.
  assign dx_c = {1'b0, sx} - {1'b0, cx};
  assign dy_c = {1'b0, sy} - {1'b0, cy};

  // The explicit sx>=cx / sy>=cy tests reject pixels left of or above the
  // sprite, whose offsets would otherwise wrap to large positive values.
  always_comb begin
    in_spr_c = (sx >= cx) && (dx_c < BOX_W) && (sy >= cy) && (dy_c < BOX_H);
  end

  // Stage 1 captures the sprite-relative offsets, the hit test and the timing
  // signals. Syncs reset high because the 640x480 mode uses negative sync.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      s1_dx     <= '0;
      s1_dy     <= '0;
      s1_in_spr <= 1'b0;
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
      s1_de     <= 1'b0;
    end else begin
      s1_dx     <= dx_c;
      s1_dy     <= dy_c;
      s1_in_spr <= in_spr_c;
      s1_hsync  <= hsync;
      s1_vsync  <= vsync;
      s1_de     <= de;
    end
  end

  // Dropping the scale bits turns screen offsets into bitmap coordinates.
  assign col     = s1_dx[SCALE_LOG2 +: COL_W];
  assign row     = s1_dy[SCALE_LOG2 +: ROW_W];
  assign spr_bit = sprite_bit(anim, row, col);

`ifdef SPRITE_BBOX_EN
  logic on_edge;

  // A pixel sits on the outline when its offset is at either end of the box
  // in either direction; only meaningful while inside the box.
  assign on_edge = (s1_dx == '0) || (s1_dx == BOX_W - 1'b1) ||
                   (s1_dy == '0) || (s1_dy == BOX_H - 1'b1);

  // Colour priority: blanking is black, then outline, then bitmap, then
  // background.
  always_comb begin
    pix = BLACK_RGB;
    if (s1_de) begin
      pix = BG_RGB;
      if (s1_in_spr && on_edge) begin
        pix = BBOX_RGB;
      end else if (s1_in_spr && spr_bit) begin
        pix = FG_RGB;
      end
    end
  end
`else
  logic unused_offset_bits;

  // Only the bitmap-index slices of the offsets feed the colour in this build.
  assign unused_offset_bits = ^{s1_dx, s1_dy};

  // Colour priority: blanking is black, then bitmap, then background.
  always_comb begin
    pix = BLACK_RGB;
    if (s1_de) begin
      pix = BG_RGB;
      if (s1_in_spr && spr_bit) begin
        pix = FG_RGB;
      end
    end
  end
`endif

  // Stage 2 registers the final colour together with the twice-delayed
  // timing so the output registers see one aligned pixel per clock.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_o     <= 4'h0;
      g_o     <= 4'h0;
      b_o     <= 4'h0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
      de_o    <= 1'b0;
    end else begin
      r_o     <= pix.r;
      g_o     <= pix.g;
      b_o     <= pix.b;
      hsync_o <= s1_hsync;
      vsync_o <= s1_vsync;
      de_o    <= s1_de;
    end
  end

endmodule

// File: doc/invader_sprite_renderer.md
Name: invader_sprite_renderer

Overview:
- Pixel-pipeline stage between dvi_controller and the DVI Pmod output registers.
- Consumes the raster position and sync signals, draws one scaled two-frame animated invader sprite over a flat background, and emits 4-bit RGB with sync/de delayed to match.
- Sprite position comes from game logic and is committed only at the start of vertical blank, so the sprite never tears.

Parameters:
- CORDW, 10, screen coordinate width in bits.
- V_RES, 480, first blanking line; the commit event occurs at sy==V_RES.
- SPR_W, 16, sprite bitmap width in pixels.
- SPR_H, 8, sprite bitmap height in pixels.
- SCALE_LOG2, 2, magnification is 2^SCALE_LOG2, giving a 64x32 on-screen sprite.
- ANIM_FRAMES, 30, number of video frames per animation bitmap toggle (>=1).

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix  in  1  synchronous reset, active-high.
- sx  in  CORDW  raster x from dvi_controller.
- sy  in  CORDW  raster y from dvi_controller.
- hsync  in  1  horizontal sync from dvi_controller.
- vsync  in  1  vertical sync from dvi_controller.
- de  in  1  data enable from dvi_controller.
- pos_x  in  CORDW  requested sprite left edge.
- pos_y  in  CORDW  requested sprite top edge.
- pos_valid  in  1  single-cycle strobe that captures pos_x/pos_y into the pending register.
- hsync_o  out  1  hsync delayed 2 cycles.
- vsync_o  out  1  vsync delayed 2 cycles.
- de_o  out  1  de delayed 2 cycles.
- r_o  out  4  red.
- g_o  out  4  green.
- b_o  out  4  blue.

Behaviour:
- Reset, synchronous with rst_pix high:
  - Both pipeline stages are cleared.
  - r_o/g_o/b_o=0, de_o=0, hsync_o=1, vsync_o=1 (inactive; 640x480 uses negative sync).
  - Pending and committed positions are both set to (0,0).
  - Frame counter=0, animation select=0.
  - Reset asserted mid-frame takes effect on the next edge; no partial state survives.
- Position capture:
  - pos_valid=1 loads the pending register; a later strobe overwrites an earlier one.
  - Commit event: sx==0 && sy==V_RES, evaluated on the stage-0 inputs. On this event, committed position <= pending.
  - If pos_valid coincides with the commit event, the new pos_x/pos_y are committed directly (bypass), and pending is loaded with them as well.
- Animation:
  - The frame counter increments on each commit event.
  - When the counter reaches ANIM_FRAMES-1 it wraps to 0 and the animation select toggles.
  - ANIM_FRAMES=1 toggles every frame.
- Pipeline, fixed latency 2 cycles:
  - Stage 1 registers:
    - dx = sx - cx and dy = sy - cy, computed CORDW+1 bits wide.
    - in_spr = (sx>=cx) && (dx < SPR_W<<SCALE_LOG2) && (sy>=cy) && (dy < SPR_H<<SCALE_LOG2).
    - Delayed hsync/vsync/de.
  - Stage 2:
    - col = dx>>SCALE_LOG2 and row = dy>>SCALE_LOG2.
    - The bitmap bit is sprite_rom[anim][row][SPR_W-1-col]; column 0 is the MSB.
    - Outputs are registered.
- Colour:
  - de_o=0 gives black.
  - de_o=1 with in_spr and bit=1 gives FG 4'hF/4'hF/4'hF.
  - Otherwise, BG 4'h1/4'h3/4'h7.
- Clipping: a sprite extending past the right or bottom edge is clipped; no wrap-around. With cx>=640, nothing is drawn.
- The position used for a given frame is constant across all its active lines.

Optional Feature:
- Macro SPRITE_BBOX_EN.
- Defined: pixels on the outer 1-pixel perimeter of the scaled sprite box (dx==0, dx==63, dy==0 or dy==31 at the defaults) are drawn in 4'hF/4'h0/4'h0 (red), overriding the bitmap. Latency is unchanged.
- Undefined: no perimeter logic; colour follows the bitmap only.

Decomposition:
- Package invader_pkg holds:
  - Constants SPR_W_DEF, SPR_H_DEF.
  - Colour constants FG_*, BG_*, BBOX_*.
  - Typedef rgb4_t (struct of three logic [3:0]).
  - The two 8x16 sprite bitmaps as localparam arrays.
- One sub-module, sprite_pos_latch: pending/committed registers, commit-event detection, bypass, frame counter and animation toggle.

Test Plan:
- Reset: assert rst_pix for 3 cycles mid-line -> r/g/b=0, de_o=0, hsync_o=1, vsync_o=1 during reset. The first valid pixel appears 2 cycles after the first de=1 following release.
- Latency/alignment: drive de, hsync and vsync pulses -> hsync_o/vsync_o/de_o are the same waveform shifted exactly 2 cycles.
- Placement: pos (100,50) strobed, then one commit -> pixel (100,50) takes bitmap bit [0][0]. Pixels (99,50) and (164,50) are BG 1/3/7. (163,81) is the last in-sprite pixel.
- Tear-free: strobe pos (300,200) at sy=100 -> the current frame still draws at the old position; the next frame draws at (300,200). A strobe coinciding with the commit event takes effect in the next frame (bypass).
- Animation: ANIM_FRAMES=2, run 5 commit events -> anim select sequence 0,0,1,1,0,0 after each event, checked via a bitmap-differing pixel.
- Clipping: pos (600,460) -> columns 600..639 and rows 460..479 are drawn, and nothing appears at sx<600 on any line. With SPRITE_BBOX_EN, pixel (600,460) is red.
